// File: rtl/shift_rg_pkg.sv
// Shared types and constants for the shift-register chain sequencer.
package shift_rg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    LOAD  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // One shift every ~0.42 s with a 10 MHz clk.
  localparam int unsigned DIV_MAX_10MHZ = 4194303;

endpackage

// File: rtl/shift_rg_tick.sv
// Shift-rate divider: free-running while not cleared; tick when the count sits at DIV_MAX.
module shift_rg_tick #(
  parameter int unsigned DIV_MAX = 4194303,
  parameter int          DIV_W   = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick_en,
  output logic tick
);

  localparam logic [DIV_W-1:0] TERM = DIV_W'(DIV_MAX);

  logic [DIV_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (count == TERM) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = tick_en && (count == TERM);

endmodule

// File: rtl/shift_rg_sequencer.sv
// Bit-serial loader for the D-trigger shift chain, MSB first, single clock domain.
// Build option: SHIFT_RG_LOOP_EN makes the pattern recirculate until abort or rst.
module shift_rg_sequencer
  import shift_rg_pkg::*;
#(
  parameter int          N       = 8,
  parameter int unsigned DIV_MAX = DIV_MAX_10MHZ,
  parameter int          DIV_W   = 26
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic [N-1:0]             pattern,
  output logic                     ser_out,
  output logic                     shift_en,
  output logic                     clr,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(N+1)-1:0]   bit_cnt,
  output state_t                   state_dbg
);

  localparam int               CNT_W = $clog2(N+1);
  localparam logic [CNT_W-1:0] CNT_N = CNT_W'(N);

  state_t           state;
  logic [N-1:0]     shadow;
  logic [N-1:0]     shadow_next;
  logic [CNT_W-1:0] cnt_inc;
  logic             last_shift;
  logic             tick;
  logic             div_clear;

  // Controls are sampled at the clk edge: start is taken only in IDLE, abort only
  // in CLEAR/LOAD; an abort seen on the edge that would raise shift_en wins over it.
  assign div_clear = !((state == CLEAR) || (state == LOAD)) || abort;

  shift_rg_tick #(
    .DIV_MAX (DIV_MAX),
    .DIV_W   (DIV_W)
  ) u_tick (
    .clk     (clk),
    .rst     (rst),
    .clear   (div_clear),
    .tick_en (state == LOAD),
    .tick    (tick)
  );

  always_comb begin
    shadow_next = shadow;
    cnt_inc     = bit_cnt;
`ifdef SHIFT_RG_LOOP_EN
    shadow_next = {shadow[N-2:0], shadow[N-1]};
    cnt_inc     = (bit_cnt == CNT_N) ? CNT_W'(1) : bit_cnt + 1'b1;
`else
    shadow_next = {shadow[N-2:0], 1'b0};
    cnt_inc     = bit_cnt + 1'b1;
`endif
    last_shift  = (cnt_inc == CNT_N);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      shadow   <= '0;
      shift_en <= 1'b0;
      clr      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bit_cnt  <= '0;
    end else begin
      shift_en <= 1'b0;
      clr      <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= CLEAR;
            shadow  <= pattern;
            bit_cnt <= '0;
            clr     <= 1'b1;
            busy    <= 1'b1;
          end
        end
        CLEAR, LOAD: begin
          if (abort) begin
            // Clearing shadow too keeps ser_out at 0 while the chain is wiped.
            state   <= IDLE;
            shadow  <= '0;
            bit_cnt <= '0;
            clr     <= 1'b1;
            busy    <= 1'b0;
          end else if (state == CLEAR) begin
            state <= LOAD;
          end else begin
            shift_en <= tick;
            if (shift_en) begin
              shadow  <= shadow_next;
              bit_cnt <= cnt_inc;
              if (last_shift) begin
                done <= 1'b1;
`ifndef SHIFT_RG_LOOP_EN
                state <= DONE;
                busy  <= 1'b0;
`endif
              end
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // shadow is a register, so ser_out is a registered output without an extra stage.
  assign ser_out   = shadow[N-1];
  assign state_dbg = state;

endmodule
